// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: range-checks decoded fields, packs them
// into a 32-bit instruction word and buffers results in a FWFT output FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic               accept;

  logic               e_valid;
  logic [31:0]        e_instr;
  logic               e_err;

  logic [32:0]        mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      occ;
  logic               push;
  logic               pop;

  assign imm_s = in_imm;

  // Pack fields per format and flag out-of-range or misaligned immediates
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (in_fmt)
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        enc_err   = (in_imm[11:0] != 12'd0);
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_instr = '0;
  end

  // Readiness counts the encode-stage word so its FIFO push can never overflow
  assign occ       = count + CW'(e_valid);
  assign in_ready  = (occ < CW'(DEPTH));
  assign accept    = in_valid && in_ready;

  assign out_valid = (count != '0);
  assign push      = e_valid;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : '0;
  assign out_err   = out_valid && mem[rd_ptr][32];

  // Encode stage and statistics counters, updated on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid   <= 1'b0;
      e_instr   <= '0;
      e_err     <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      e_valid <= accept;
      if (accept) begin
        e_instr   <= enc_instr;
        e_err     <= enc_err;
        enc_count <= enc_count + CNT_W'(1);
        if (enc_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only visible while out_valid is high
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {e_err, e_instr};
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// backpressure/streaming/reset sequences, and randomized traffic against a model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: FIFO contents, encode-stage slot, counters
  logic [32:0]      mq[$];
  logic             e_full = 1'b0;
  logic [32:0]      e_word = '0;
  logic [CNT_W-1:0] m_enc = '0;
  logic [CNT_W-1:0] m_err = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding built from bit-field arithmetic on the immediate value
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    longint    v;
    bit [31:0] u, w, o, d, f, s1, s2;
    bit        e;
    v  = longint'($signed(imm));
    u  = imm;
    o  = 32'(op);
    d  = 32'(rd) << 7;
    f  = 32'(f3) << 12;
    s1 = 32'(rs1) << 15;
    s2 = 32'(rs2) << 20;
    e  = 1'b0;
    w  = '0;
    case (fmt)
      3'd0: w = o | d | f | s1 | s2 | (32'(f7) << 25);
      3'd1: begin
        e = (v < -2048) || (v > 2047);
        w = o | d | f | s1 | ((u % 4096) << 20);
      end
      3'd2: begin
        e = (v < -2048) || (v > 2047);
        w = o | f | s1 | s2 | ((u % 32) << 7) | (((u / 32) % 128) << 25);
      end
      3'd3: begin
        e = (v < -4096) || (v > 4094) || (u % 2 != 0);
        w = o | f | s1 | s2 | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8)
              | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
      end
      3'd4: begin
        e = (u % 4096) != 0;
        w = o | d | (u - (u % 4096));
      end
      3'd5: begin
        e = (v < -1048576) || (v > 1048574) || (u % 2 != 0);
        w = o | d | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
              | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
      end
      default: e = 1'b1;
    endcase
    if (e) w = '0;
    return {e, w};
  endfunction

  function automatic void add(input int fmt, input int op, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input int imm,
      input logic [31:0] exp_instr, input logic exp_err);
    vec_t t;
    t.fmt = 3'(fmt); t.op = 7'(op); t.f3 = 3'(f3); t.f7 = 7'(f7);
    t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.imm = 32'(imm);
    t.exp_instr = exp_instr; t.exp_err = exp_err;
    vecs.push_back(t);
  endfunction

  task automatic drive(input vec_t t);
    in_fmt = t.fmt; in_opcode = t.op; in_funct3 = t.f3; in_funct7 = t.f7;
    in_rd = t.rd; in_rs1 = t.rs1; in_rs2 = t.rs2; in_imm = t.imm;
  endtask

  task automatic rand_fields();
    int unsigned mode;
    in_fmt    = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    mode      = $urandom_range(0, 3);
    case (mode)
      0: in_imm = $urandom;
      1: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
      default: in_imm = $urandom & 32'hFFFF_F000;
    endcase
  endtask

  task automatic check_state();
    chk("in_ready", 32'(in_ready), 32'((mq.size() + int'(e_full)) < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_instr", out_instr, mq[0][31:0]);
      chk("head_err", 32'(out_err), 32'(mq[0][32]));
    end
    chk("enc_count", 32'(enc_count), 32'(m_enc));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  // One clock: check at the falling edge, then advance model and DUT together
  task automatic cycle(output bit acc);
    bit          pop;
    logic [32:0] nw;
    check_state();
    acc = in_valid && ((mq.size() + int'(e_full)) < DEPTH);
    pop = (mq.size() != 0) && out_ready;
    nw  = ref_enc(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (e_full) mq.push_back(e_word);
    e_full = acc;
    if (acc) begin
      e_word = nw;
      m_enc  = m_enc + 1'b1;
      if (nw[32] && (m_err != '1)) m_err = m_err + 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int accepted;
    int n_err_tbl;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors: legal encodings, range boundaries and error cases
    add(1, 'h13, 0, 0,    1, 0, 0, 5,            32'h00500093, 0);
    add(2, 'h23, 2, 0,    0, 1, 2, 8,            32'h0020A423, 0);
    add(3, 'h63, 0, 0,    0, 0, 0, -4,           32'hFE000EE3, 0);
    add(5, 'h6F, 0, 0,    1, 0, 0, 2048,         32'h001000EF, 0);
    add(4, 'h37, 0, 0,    5, 0, 0, 'h12345000,   32'h123452B7, 0);
    add(0, 'h33, 0, 'h20, 3, 1, 2, 'h7EADBEEF,   32'h402081B3, 0);
    add(1, 'h13, 0, 0,    0, 0, 0, -2048,        32'h80000013, 0);
    add(1, 'h13, 0, 'h7F, 0, 0, 31, 2047,        32'h7FF00013, 0);
    add(2, 'h23, 0, 0,    0, 0, 0, -2048,        32'h80000023, 0);
    add(3, 'h63, 0, 0,    0, 0, 0, 4094,         32'h7E000FE3, 0);
    add(3, 'h63, 0, 0,    0, 0, 0, -4096,        32'h80000063, 0);
    add(5, 'h6F, 0, 0,    0, 0, 0, -1048576,     32'h8000006F, 0);
    add(5, 'h6F, 0, 0,    0, 0, 0, 1048574,      32'h7FFFF06F, 0);
    add(1, 'h13, 0, 0,    1, 0, 0, 2048,         32'h00000000, 1);
    add(3, 'h63, 0, 0,    0, 0, 0, 3,            32'h00000000, 1);
    add(4, 'h37, 0, 0,    5, 0, 0, 'h00001001,   32'h00000000, 1);
    add(7, 'h13, 0, 0,    1, 0, 0, 0,            32'h00000000, 1);
    add(6, 'h13, 0, 0,    1, 0, 0, 0,            32'h00000000, 1);
    add(2, 'h23, 0, 0,    0, 0, 0, -2049,        32'h00000000, 1);
    add(3, 'h63, 0, 0,    0, 0, 0, 4096,         32'h00000000, 1);
    add(5, 'h6F, 0, 0,    0, 0, 0, 1048576,      32'h00000000, 1);
    add(5, 'h6F, 0, 0,    0, 0, 0, 5,            32'h00000000, 1);

    n_err_tbl = 0;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_instr", out_instr, vecs[i].exp_instr);
      chk("tbl_err", 32'(out_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) n_err_tbl++;
      cycle(acc);
    end
    chk("tbl_enc_total", 32'(enc_count), 32'(vecs.size()));
    chk("tbl_err_total", 32'(err_count), 32'(n_err_tbl));

    // Backpressure: consumer stalled, producer always valid
    out_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      in_valid = 1'b1;
      cycle(acc);
      if (acc) accepted++;
    end
    chk("bp_accepted", 32'(accepted), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      in_valid = 1'b1;
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      cycle(acc);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) cycle(acc);

    // Streaming: ten back-to-back words with no bubbles at the output
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 10);
      if (k < 10) begin
        rand_fields();
        chk("stream_in_ready", 32'(in_ready), 32'd1);
      end
      if (k >= 2) chk("stream_out_valid", 32'(out_valid), 32'd1);
      cycle(acc);
    end
    for (int k = 0; k < 3; k++) cycle(acc);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle(acc);

    // Reset with words buffered: clears asynchronously, nothing stale afterwards
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_fields();
      in_valid = 1'b1;
      cycle(acc);
    end
    in_valid = 1'b0;
    cycle(acc);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_enc", 32'(enc_count), 32'd0);
    chk("async_rst_err", 32'(err_count), 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    in_valid = 1'b1;
    in_fmt = 3'd7;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    e_full = 1'b0;
    m_enc = '0;
    m_err = '0;
    chk("rst_no_accept", 32'(enc_count), 32'd0);
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(vecs[0]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_instr", out_instr, 32'h00500093);
    chk("post_rst_err", 32'(out_err), 32'd0);
    chk("post_rst_enc", 32'(enc_count), 32'd1);
    cycle(acc);
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the core's immediate-generation and decode path. It takes decoded fields (format, opcode, funct3, funct7, rd, rs1, rs2 and a full 32-bit signed immediate) and range-checks and packs them into a 32-bit instruction word. It feeds the instruction-memory loader and self-test generator through a valid/ready interface with an internal output FIFO.

Parameters:
DEPTH, 4, output FIFO entries (power of two, ≥2)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept this cycle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_opcode  in  7  opcode placed at [6:0]
in_funct3  in  3  placed at [14:12] (R/I/S/B)
in_funct7  in  7  placed at [31:25] (R only)
in_rd  in  5  placed at [11:7] (R/I/U/J)
in_rs1  in  5  placed at [19:15] (R/I/S/B)
in_rs2  in  5  placed at [24:20] (R/S/B)
in_imm  in  32  signed immediate as produced by immediate generation (U: full shifted value)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_instr  out  32  encoded word (0 when out_err)
out_err  out  1  immediate/format error for this word
enc_count  out  CNT_W  words accepted; wraps
err_count  out  CNT_W  error words accepted; saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous): encode stage empty, FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. All in-flight words are discarded. in_ready is 1 once rst_n is high.
- Accept when in_valid && in_ready. in_ready = (fifo_count + e_valid) < DEPTH. It depends on state only, never combinationally on out_ready.
- Encode stage E: captures the packed word and the error bit on the accept edge.
  - The next edge always moves E into the FIFO. Space is guaranteed by the in_ready rule.
  - E may load a new word on that same edge.
- FIFO is first-word-fall-through; out_instr/out_err show the head.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop are legal at any fill level.
  - Order is strictly preserved.
- Latency: a word accepted at edge N reaches the FIFO at edge N+1. If the FIFO was empty, out_valid is high after edge N+1. Sustained throughput is 1 word/cycle while out_ready=1.
- Packing per fmt (fields not listed are 0):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Error conditions (error → out_instr=0, out_err=1; word still occupies a FIFO slot):
  - I/S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094] or imm[0]=1.
  - J: imm not in [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] != 0.
  - fmt 6/7: always an error.
  - R: imm ignored, never an error.
- Counters: enc_count increments on every accept. err_count increments on accept of an error word and holds at max. Both update on the accept edge.
- Reset mid-stream: all state clears immediately, with no partial output. A word presented during reset is not accepted.

Test Plan:
1. I fmt, op 0x13, f3 0, rd 1, rs1 0, imm 5 → out_instr 0x00500093 one edge after accept, out_err 0, enc_count 1.
2. S fmt op 0x23 f3 2 rs1 1 rs2 2 imm 8 → 0x0020A423. B fmt op 0x63 f3 0 rs1/rs2 0 imm -4 → 0xFE000EE3. J fmt op 0x6F rd 1 imm 2048 → 0x001000EF. U fmt op 0x37 rd 5 imm 0x12345000 → 0x123452B7.
3. Errors: I imm 2048; B imm 3; U imm 0x00001001; fmt 7 → each gives out_err 1 and out_instr 0. err_count reaches 4; enc_count counts all of them.
4. Backpressure: out_ready=0, in_valid held high → exactly DEPTH (4) words accepted, then in_ready 0. Raising out_ready drains the words in order at 1/cycle while new words continue to be accepted.
5. Back-to-back streaming with out_ready=1 for 10 words → in_ready stays high and there are no bubbles after the first word.
6. Deassert rst_n with 3 words buffered → out_valid 0, both counters 0 asynchronously. After release, the first new word produces correct output with no stale data.
